multdiv_seq_ctrl: RTL and testbench

//  Iteration sequencer for the multiply/divide unit. Accepts one-cycle ctrl_MULT/ctrl_DIV

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_step_cnt.sv | 34 +++
 rtl/multdiv_seq_ctrl.sv | 101 ++++++++++
 tb/tb_multdiv_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide iteration sequencer.
package multdiv_pkg;

    localparam int MULT_STEPS_DEF = 32;
    localparam int DIV_STEPS_DEF  = 32;
    localparam int CNT_W_DEF      = 6;

    // One-hot so each state-decoded output is a single flop bit.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } mds_state_e;

endpackage

// File: rtl/multdiv_step_cnt.sv
// Step counter for the multdiv sequencer: toggle-style up counter,
// async clear, synchronous clear (priority) and count enable.
module multdiv_step_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] tgl;

    // Bit i flips when enabled and every lower bit is already 1.
    genvar i;
    generate
        for (i = 0; i < CNT_W; i++) begin : g_tgl
            if (i == 0) begin : g_lsb
                assign tgl[i] = en;
            end else begin : g_upper
                assign tgl[i] = en & (&cnt[i-1:0]);
            end
        end
    endgenerate

    // Counter register; synchronous clear overrides counting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)       cnt <= '0;
        else if (sclr) cnt <= '0;
        else           cnt <= cnt ^ tgl;
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Multiply/divide iteration sequencer: IDLE -> LOAD -> RUN -> DONE.
// Optional macro MULTDIV_DIV0_FASTEXIT_EN: a divide by zero skips RUN
// and goes LOAD -> DONE directly.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    output logic             load,
    output logic             op_is_div,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             done,
    output logic             exception
);

    // Step counts outside 1..63, or too large for the counter, are rejected.
    if (MULT_STEPS < 1 || MULT_STEPS > 63 || DIV_STEPS < 1 || DIV_STEPS > 63 ||
        MULT_STEPS > (2 ** CNT_W) || DIV_STEPS > (2 ** CNT_W)) begin : g_bad_param
        $error("multdiv_seq_ctrl: illegal MULT_STEPS/DIV_STEPS/CNT_W");
    end

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    mds_state_e       state, state_nx;
    logic             start;
    logic             last;
    logic             fast_exit;
    logic             exc_q;
    logic [CNT_W-1:0] cnt;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last  = (cnt == (op_is_div ? DIV_LAST : MULT_LAST));

`ifdef MULTDIV_DIV0_FASTEXIT_EN
    assign fast_exit = op_is_div & div_by_zero;
`else
    assign fast_exit = 1'b0;
`endif

    // Counter cleared on any (re)start and in LOAD; it stops at N-1 rather than wrapping.
    multdiv_step_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .clr  (clr),
        .sclr (start | (state == LOAD)),
        .en   ((state == RUN) & ~last),
        .cnt  (cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: a start from any state (re)enters LOAD with the new op.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (start)          state_nx = LOAD;
                     else if (fast_exit) state_nx = DONE;
                     else                state_nx = RUN;
            RUN:     if (start)     state_nx = LOAD;
                     else if (last) state_nx = DONE;
            DONE:    if (start) state_nx = LOAD;
                     else       state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operation type latched on start; multiply wins when both pulses arrive together.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)        op_is_div <= 1'b0;
        else if (start) op_is_div <= ~ctrl_MULT;
    end

    // Divide-by-zero flag captured in LOAD; a multiply always clears it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                exc_q <= 1'b0;
        else if (state == LOAD) exc_q <= op_is_div & div_by_zero;
    end

    // Outputs decode straight from state flops; step_idx reads 0 outside RUN.
    assign load      = (state == LOAD);
    assign step_en   = (state == RUN);
    assign busy      = (state == LOAD) | (state == RUN);
    assign done      = (state == DONE);
    assign exception = (state == DONE) & exc_q;
    assign step_idx  = step_en ? cnt : '0;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Self-checking bench for multdiv_seq_ctrl with a cycle-timeline reference model.
module tb_multdiv_seq_ctrl;

    localparam int MS = 32;
    localparam int DS = 33;
`ifdef MULTDIV_DIV0_FASTEXIT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       ctrl_MULT, ctrl_DIV, div_by_zero;
    logic       load, op_is_div, step_en, busy, done, exception;
    logic [5:0] step_idx;
    logic [11:0] obs, expv;
    int tests = 0;
    int fails = 0;

    multdiv_seq_ctrl #(.MULT_STEPS(MS), .DIV_STEPS(DS), .CNT_W(6)) dut (
        .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .div_by_zero(div_by_zero), .load(load), .op_is_div(op_is_div),
        .step_en(step_en), .step_idx(step_idx), .busy(busy), .done(done),
        .exception(exception)
    );

    always #5 clk = ~clk;

    assign obs = {load, busy, step_en, step_idx, done, exception, op_is_div};

    // Expected outputs k cycles after a start pulse (k=1 is the load cycle),
    // assuming no further start.
    function automatic logic [11:0] model(int k, bit div, bit dbz);
        int n;
        bit fast, ld, bz, se, dn, ex;
        logic [5:0] idx;
        n = div ? DS : MS;
        fast = FAST && div && dbz;
        ld = 0; bz = 0; se = 0; dn = 0; ex = 0; idx = '0;
        if (k == 1) begin
            ld = 1; bz = 1;
        end else if (fast) begin
            if (k == 2) begin dn = 1; ex = 1; end
        end else if (k >= 2 && k <= n + 1) begin
            bz = 1; se = 1; idx = 6'(k - 2);
        end else if (k == n + 2) begin
            dn = 1; ex = div & dbz;
        end
        return {ld, bz, se, idx, dn, ex, div};
    endfunction

    function automatic int done_cycle(bit div, bit dbz);
        if (FAST && div && dbz) return 2;
        return (div ? DS : MS) + 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse the start inputs for one cycle; leaves the bench in the load cycle
    // with div_by_zero set to the value LOAD should sample.
    task automatic drive_start(bit m, bit d, bit dbz);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        step();
        ctrl_MULT   = 1'b0;
        ctrl_DIV    = 1'b0;
        div_by_zero = dbz;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (obs !== 12'h000) begin
            fails++; $display("FAIL reset_init got=%h exp=%h", obs, 12'h000);
        end
        step(); step();
        clr = 1'b0;
        step();
        // Multiply up to step_idx=10, then assert clr mid-cycle.
        drive_start(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            expv = model(k, 1'b0, 1'b0);
            tests++;
            if (obs !== expv) begin
                fails++; $display("FAIL reset_run k=%0d got=%h exp=%h", k, obs, expv);
            end
            if (k < 12) step();
        end
        clr = 1'b1;
        #1;
        tests++;
        if (obs !== 12'h000) begin
            fails++; $display("FAIL reset_async got=%h exp=%h", obs, 12'h000);
        end
        step();
        clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            div_by_zero = 1'($urandom);
            step();
            tests++;
            if (obs !== 12'h000) begin
                fails++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs, 12'h000);
            end
        end
    endtask

    task automatic test_random_ops();
        bit d, z;
        // First two fixed: plain multiply, divide by zero; then random.
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom);
            z = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom);
            drive_start(~d, d, z);
            for (int k = 1; k <= (d ? DS : MS) + 3; k++) begin
                expv = model(k, d, z);
                tests++;
                if (obs !== expv) begin
                    fails++;
                    $display("FAIL op%0d div=%0d dbz=%0d k=%0d got=%h exp=%h", i, d, z, k, obs, expv);
                end
                if (k >= 2) div_by_zero = 1'($urandom);
                step();
            end
        end
    endtask

    task automatic test_both_pulses();
        drive_start(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= MS + 3; k++) begin
            expv = model(k, 1'b0, 1'b1);
            tests++;
            if (obs !== expv) begin
                fails++; $display("FAIL both_pulses k=%0d got=%h exp=%h", k, obs, expv);
            end
            if (k >= 2) div_by_zero = 1'($urandom);
            step();
        end
    endtask

    // Multiply interrupted by a divide start at a given cycle (k=7 is step_idx 5).
    task automatic test_abort();
        int kab;
        bit z;
        for (int i = 0; i < 4; i++) begin
            kab = (i == 0) ? 7 : $urandom_range(1, MS + 1);
            z = 1'($urandom);
            drive_start(1'b1, 1'b0, 1'b0);
            for (int k = 1; k <= kab; k++) begin
                expv = model(k, 1'b0, 1'b0);
                tests++;
                if (obs !== expv) begin
                    fails++; $display("FAIL abort_old%0d k=%0d got=%h exp=%h", i, k, obs, expv);
                end
                if (k < kab) begin
                    if (k >= 2) div_by_zero = 1'($urandom);
                    step();
                end
            end
            drive_start(1'b0, 1'b1, z);
            for (int k = 1; k <= DS + 3; k++) begin
                expv = model(k, 1'b1, z);
                tests++;
                if (obs !== expv) begin
                    fails++; $display("FAIL abort_new%0d kab=%0d k=%0d got=%h exp=%h", i, kab, k, obs, expv);
                end
                if (k >= 2) div_by_zero = 1'($urandom);
                step();
            end
        end
    endtask

    // New start issued in the done cycle of the previous op.
    task automatic test_back_to_back();
        bit d0, z0, d1, z1;
        int kd;
        d0 = 1'b1; z0 = 1'b0;
        drive_start(1'b0, d0, z0);
        for (int i = 0; i < 5; i++) begin
            d1 = (i == 0) ? 1'b1 : 1'($urandom);
            z1 = (i == 0) ? 1'b0 : 1'($urandom);
            kd = done_cycle(d0, z0);
            for (int k = 1; k <= kd; k++) begin
                expv = model(k, d0, z0);
                tests++;
                if (obs !== expv) begin
                    fails++; $display("FAIL b2b%0d k=%0d got=%h exp=%h", i, k, obs, expv);
                end
                if (k < kd) begin
                    if (k >= 2) div_by_zero = 1'($urandom);
                    step();
                end
            end
            drive_start(~d1, d1, z1);
            d0 = d1; z0 = z1;
        end
        for (int k = 1; k <= (d0 ? DS : MS) + 3; k++) begin
            expv = model(k, d0, z0);
            tests++;
            if (obs !== expv) begin
                fails++; $display("FAIL b2b_tail k=%0d got=%h exp=%h", k, obs, expv);
            end
            if (k >= 2) div_by_zero = 1'($urandom);
            step();
        end
    endtask

    // Without starts the outputs idle at 0 while op_is_div keeps the last op.
    task automatic test_idle_hold();
        for (int i = 0; i < 2; i++) begin
            drive_start(bit'(i), bit'(1 - i), 1'b0);
            for (int k = 1; k <= DS + 3; k++) step();
            for (int c = 0; c < 6; c++) begin
                div_by_zero = 1'($urandom);
                expv = {11'b0, 1'(1 - i)};
                tests++;
                if (obs !== expv) begin
                    fails++; $display("FAIL idle_hold%0d c=%0d got=%h exp=%h", i, c, obs, expv);
                end
                step();
            end
        end
    endtask

    initial begin
        clr = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; div_by_zero = 1'b0;
        test_reset();
        test_random_ops();
        test_both_pulses();
        test_abort();
        test_back_to_back();
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
